// File: rtl/pkg_config.sv
// Shared configuration for the ALU datapath: operand width, ALU op encoding
// and a legality helper used wherever an op code must be screened.
package pkg_config;

  localparam int DATA_WIDTH = 32;
  localparam int ALU_OP_W   = 6;

  localparam logic [ALU_OP_W-1:0] OP_ALU_ADD  = 6'h00;
  localparam logic [ALU_OP_W-1:0] OP_ALU_SUB  = 6'h01;
  localparam logic [ALU_OP_W-1:0] OP_ALU_SLL  = 6'h02;
  localparam logic [ALU_OP_W-1:0] OP_ALU_SLT  = 6'h03;
  localparam logic [ALU_OP_W-1:0] OP_ALU_SLTU = 6'h04;
  localparam logic [ALU_OP_W-1:0] OP_ALU_XOR  = 6'h05;
  localparam logic [ALU_OP_W-1:0] OP_ALU_SRL  = 6'h06;
  localparam logic [ALU_OP_W-1:0] OP_ALU_SRA  = 6'h07;
  localparam logic [ALU_OP_W-1:0] OP_ALU_OR   = 6'h08;
  localparam logic [ALU_OP_W-1:0] OP_ALU_AND  = 6'h09;

  function automatic bit alu_op_legal(input logic [ALU_OP_W-1:0] op);
    case (op)
      OP_ALU_ADD, OP_ALU_SUB, OP_ALU_SLL, OP_ALU_SLT, OP_ALU_SLTU,
      OP_ALU_XOR, OP_ALU_SRL, OP_ALU_SRA, OP_ALU_OR, OP_ALU_AND: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_unit.sv
// Combinational RV32I-style integer ALU. Unknown op codes produce zero so
// no X ever leaves the block.
module alu_unit
  import pkg_config::*;
(
  input  logic [ALU_OP_W-1:0]   op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  logic [SHAMT_W-1:0] shamt;
  assign shamt = b_i[SHAMT_W-1:0];

  always_comb begin
    // NOTE: default assigned first so every path drives result_o; no latch is inferred.
    result_o = '0;
    case (op_i)
      OP_ALU_ADD:  result_o = a_i + b_i;
      OP_ALU_SUB:  result_o = a_i - b_i;
      OP_ALU_SLL:  result_o = a_i << shamt;
      OP_ALU_SLT:  result_o = DATA_WIDTH'($signed(a_i) < $signed(b_i));
      OP_ALU_SLTU: result_o = DATA_WIDTH'(a_i < b_i);
      OP_ALU_XOR:  result_o = a_i ^ b_i;
      OP_ALU_SRL:  result_o = a_i >> shamt;
      OP_ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      OP_ALU_OR:   result_o = a_i | b_i;
      OP_ALU_AND:  result_o = a_i & b_i;
      default:     result_o = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr_i,
// wrapping past N-1 back to 0. Returns one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o
);

  int pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    pos     = 0;
    // Walk offsets from farthest to nearest so the nearest valid request wins.
    for (int k = N - 1; k >= 0; k--) begin
      pos = (int'(ptr_i) + k) % N;
      if (req_i[pos]) begin
        grant_o      = '0;
        grant_o[pos] = 1'b1;
        idx_o        = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters with round-robin
// arbitration and a single registered result slot tagged with requester ID.
module alu_share_arbiter
  import pkg_config::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*ALU_OP_W-1:0]     req_op_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [DATA_WIDTH-1:0]           rsp_data_o,
  output logic [ID_W-1:0]                 rsp_id_o,
  output logic                            rsp_err_o
);

  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       gnt_idx;
  logic [ID_W-1:0]       rr_q, rr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  accept, handshake, op_legal;
  logic [ALU_OP_W-1:0]   op_sel;
  logic [DATA_WIDTH-1:0] a_sel, b_sel, alu_res;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_rr_arbiter (
    .req_i   (req_valid_i),
    .ptr_i   (rr_q),
    .grant_o (grant),
    .idx_o   (gnt_idx)
  );

  assign op_sel = req_op_i[int'(gnt_idx)*ALU_OP_W +: ALU_OP_W];
  assign a_sel  = req_a_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign b_sel  = req_b_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

  alu_unit u_alu_unit (
    .op_i     (op_sel),
    .a_i      (a_sel),
    .b_i      (b_sel),
    .result_o (alu_res)
  );

  assign op_legal  = alu_op_legal(op_sel);
  assign accept    = !rsp_valid_q || rsp_ready_i;
  // Gating with rst_ni keeps ready low for the whole reset, not just after the first edge.
  assign req_ready_o = (accept && rst_ni) ? grant : '0;
  assign handshake   = |(req_valid_i & req_ready_o);

  always_comb begin
    rr_d        = rr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    if (handshake) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = op_legal ? alu_res : '0;
      rsp_id_d    = gnt_idx;
      rsp_err_d   = !op_legal;
      rr_d        = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: reset, single op, round-robin,
// backpressure, edge arithmetic/illegal op and async reset mid-operation.
module tb_alu_share_arbiter;
  import pkg_config::*;

  localparam int N  = 2;
  localparam int DW = DATA_WIDTH;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [N-1:0]         req_valid_i;
  logic [N-1:0]         req_ready_o;
  logic [N*ALU_OP_W-1:0] req_op_i;
  logic [N*DW-1:0]      req_a_i;
  logic [N*DW-1:0]      req_b_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [DW-1:0]        rsp_data_o;
  logic [0:0]           rsp_id_o;
  logic                 rsp_err_o;

  int errors = 0;
  int checks = 0;

  alu_share_arbiter #(.NUM_REQ(N)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_id_o    (rsp_id_o),
    .rsp_err_o   (rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [ALU_OP_W-1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid_i[i]                  = v;
    req_op_i[i*ALU_OP_W +: ALU_OP_W] = op;
    req_a_i[i*DW +: DW]             = a;
    req_b_i[i*DW +: DW]             = b;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [DW-1:0] d,
                           input logic id, input logic err);
    check({tag, ".valid"}, rsp_valid_o, v);
    check({tag, ".data"},  rsp_data_o,  d);
    check({tag, ".id"},    rsp_id_o,    id);
    check({tag, ".err"},   rsp_err_o,   err);
  endtask

  // Requester protocol: a stalled valid request must keep op/a/b stable.
  logic [N-1:0]          prev_hold = '0;
  logic [ALU_OP_W-1:0]   prev_op [N];
  logic [2*DW-1:0]       prev_ab [N];

  always @(negedge clk_i) begin
    for (int i = 0; i < N; i++) begin
      if (rst_ni && prev_hold[i] && req_valid_i[i]) begin
        check("proto_op", req_op_i[i*ALU_OP_W +: ALU_OP_W], prev_op[i]);
        check("proto_ab", {req_a_i[i*DW +: DW], req_b_i[i*DW +: DW]}, prev_ab[i]);
      end
      prev_hold[i] = rst_ni && req_valid_i[i] && !req_ready_o[i];
      prev_op[i]   = req_op_i[i*ALU_OP_W +: ALU_OP_W];
      prev_ab[i]   = {req_a_i[i*DW +: DW], req_b_i[i*DW +: DW]};
    end
  end

  typedef struct {
    logic [ALU_OP_W-1:0] op;
    logic [DW-1:0]       a;
    logic [DW-1:0]       b;
    logic [DW-1:0]       exp;
    logic                err;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs = '{
      '{OP_ALU_ADD,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0},
      '{OP_ALU_SRA,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0},
      '{6'h3F,       32'h0000_0123, 32'h0000_0456, 32'h0000_0000, 1'b1},
      '{OP_ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 1'b0},
      '{OP_ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0},
      '{OP_ALU_SUB,  32'h0000_0000, 32'd1,         32'hFFFF_FFFF, 1'b0},
      '{OP_ALU_SRL,  32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0},
      '{OP_ALU_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0},
      '{OP_ALU_XOR,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0}
    };

    // Reset with both requesters valid: nothing may be accepted.
    rst_ni      = 1'b0;
    rsp_ready_i = 1'b1;
    req_valid_i = '0;
    req_op_i    = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    set_req(0, 1'b1, OP_ALU_ADD, 32'd5, 32'd7);
    set_req(1, 1'b1, OP_ALU_SUB, 32'd9, 32'd4);
    #1;
    check("rst.ready", req_ready_o, 2'b00);
    check_rsp("rst", 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_clk.ready", req_ready_o, 2'b00);
    check("rst_clk.valid", rsp_valid_o, 1'b0);

    // Release between edges: pointer at 0 so requester 0 wins.
    rst_ni = 1'b1;
    #1;
    check("first_grant", req_ready_o, 2'b01);
    tick();
    check_rsp("add", 1'b1, 32'd12, 1'b0, 1'b0);
    #1;
    check("second_grant", req_ready_o, 2'b10);
    tick();
    check_rsp("sub", 1'b1, 32'd5, 1'b1, 1'b0);
    req_valid_i = '0;
    #1;
    check("idle.ready", req_ready_o, 2'b00);
    tick();
    check_rsp("drain_hold", 1'b0, 32'd5, 1'b1, 1'b0);

    // Round-robin with both valid: alternating grants, no bubbles.
    set_req(0, 1'b1, OP_ALU_SUB, 32'd10, 32'd3);
    set_req(1, 1'b1, OP_ALU_SLL, 32'd1, 32'd4);
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr.ready", req_ready_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      check_rsp("rr", 1'b1, (k % 2 == 0) ? 32'd7 : 32'd16, 1'(k % 2), 1'b0);
    end

    // Backpressure: slot full with consumer stalled.
    rsp_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp.ready", req_ready_o, 2'b00);
      check_rsp("bp", 1'b1, 32'd16, 1'b1, 1'b0);
      tick();
    end
    rsp_ready_i = 1'b1;
    #1;
    check("bp_release.ready", req_ready_o, 2'b01);
    tick();
    check_rsp("bp_release", 1'b1, 32'd7, 1'b0, 1'b0);
    req_valid_i = '0;
    #1;
    tick();
    check("bp_drained", rsp_valid_o, 1'b0);

    // Edge arithmetic and illegal op, requester 0 only (grant wraps from ptr 1).
    foreach (vecs[i]) begin
      set_req(0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      check("vec.ready", req_ready_o, 2'b01);
      tick();
      check_rsp("vec", 1'b1, vecs[i].exp, 1'b0, vecs[i].err);
    end
    req_valid_i = '0;

    // Async reset while a result is pending; pointer is 1 before the reset.
    #2;
    rst_ni = 1'b0;
    #1;
    check_rsp("async_rst", 1'b0, 32'd0, 1'b0, 1'b0);
    check("async_rst.ready", req_ready_o, 2'b00);
    tick();
    rst_ni = 1'b1;
    set_req(0, 1'b1, OP_ALU_OR,  32'h0000_00F0, 32'h0000_000F);
    set_req(1, 1'b1, OP_ALU_AND, 32'h0000_00F0, 32'h0000_000F);
    #1;
    check("post_rst.ready", req_ready_o, 2'b01);
    tick();
    check_rsp("post_rst", 1'b1, 32'h0000_00FF, 1'b0, 1'b0);
    req_valid_i = '0;
    tick();
    check("final_drain", rsp_valid_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
